// File: rtl/risc_machine_ctrl_if.sv
// Control bundle between the RISC instruction sequencer and the rest of the core.
// The master side is the sequencer: it samples run/decode inputs and drives the strobes.
interface risc_machine_ctrl_if;
  logic       ena;
  logic [2:0] opcode;
  logic       zero;
  logic       inc_pc;
  logic       load_acc;
  logic       load_pc;
  logic       rd;
  logic       wr;
  logic       load_ir;
  logic       datactl_ena;
  logic       halt;
  logic [2:0] phase;

  modport master (
    input  ena, opcode, zero,
    output inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, phase
  );

  modport slave (
    output ena, opcode, zero,
    input  inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena, halt, phase
  );
endinterface

// File: rtl/risc_machine_ctrl.sv
// Eight-phase instruction sequencer: fetch (S0-S1), decode (S2-S3), execute/write-back (S4-S6).
// Every strobe is registered, so step k strobes appear while phase reads Sk+1.
module risc_machine_ctrl (
  input  logic                  clk1,
  input  logic                  rst,
  risc_machine_ctrl_if.master   bus
);

  typedef enum logic [2:0] {S0, S1, S2, S3, S4, S5, S6, S7} phase_e;

  typedef enum logic [2:0] {
    OP_HLT  = 3'b000,
    OP_SKZ  = 3'b001,
    OP_ADD  = 3'b010,
    OP_ANDD = 3'b011,
    OP_XORR = 3'b100,
    OP_LDA  = 3'b101,
    OP_STO  = 3'b110,
    OP_JMP  = 3'b111
  } op_e;

  // Strobe vector order: {inc_pc, load_acc, load_pc, rd, wr, load_ir, datactl_ena}
  function automatic logic [6:0] step_strobes(phase_e ph, op_e op, logic z);
    logic alu;
    logic [6:0] s;
    alu = (op == OP_ADD) || (op == OP_ANDD) || (op == OP_XORR) || (op == OP_LDA);
    s   = 7'b0;
    case (ph)
      S0, S1: s = 7'b1001010;
      S4: begin
        if (alu)              s = 7'b0001000;
        else if (op == OP_STO) s = 7'b0000001;
        else if (op == OP_JMP) s = 7'b0010000;
      end
      S5: begin
        if (alu)                    s = 7'b0101000;
        else if (op == OP_STO)       s = 7'b0000101;
        else if (op == OP_JMP)       s = 7'b1010000;
        else if (op == OP_SKZ && z)  s = 7'b1000000;
      end
      S6: begin
        if (alu)                    s = 7'b0001000;
        else if (op == OP_STO)       s = 7'b0000001;
        else if (op == OP_JMP)       s = 7'b0010000;
        else if (op == OP_SKZ && z)  s = 7'b1000000;
      end
      default: s = 7'b0;
    endcase
    return s;
  endfunction

  phase_e     phase_q;
  logic       halt_q;
  logic [6:0] strobes_q;
  op_e        op;

  assign op = op_e'(bus.opcode);

  // Halt is sticky and freezes the phase at S4; only rst or dropping ena releases it.
  always_ff @(posedge clk1) begin
    if (rst || !bus.ena) begin
      phase_q   <= S0;
      halt_q    <= 1'b0;
      strobes_q <= 7'b0;
    end else if (halt_q) begin
      strobes_q <= 7'b0;
    end else begin
      strobes_q <= step_strobes(phase_q, op, bus.zero);
      halt_q    <= (phase_q == S3) && (op == OP_HLT);
      phase_q   <= phase_e'(phase_q + 3'd1);
    end
  end

  assign {bus.inc_pc, bus.load_acc, bus.load_pc, bus.rd,
          bus.wr, bus.load_ir, bus.datactl_ena} = strobes_q;
  assign bus.halt  = halt_q;
  assign bus.phase = phase_q;

endmodule

// File: doc/risc_machine_ctrl.md
# risc_machine_ctrl

Eight-phase instruction sequencer for the 8-bit-bus RISC core. It generates every per-cycle control strobe: program-counter increment and load, accumulator load, memory read and write, data-bus drive, instruction-register load, and halt. The 16-bit instruction register is loaded by the `load_ir` strobe in two consecutive cycles, high byte first. This block decodes `opcode`, which is `instr[15:13]` of that register, and the accumulator `zero` flag to sequence fetch, execute and write-back.

## Interface
- No parameters.
- `clk1` in 1 — system clock, all logic on posedge.
- `rst` in 1 — reset, synchronous, active-high.
- `ena` in 1 — run enable from the CPU start controller; 0 idles the sequencer.
- `opcode` in 3 — current instruction opcode, `instr[15:13]`.
- `zero` in 1 — accumulator-is-zero flag.
- `inc_pc` out 1 — increment PC.
- `load_acc` out 1 — load accumulator from the ALU.
- `load_pc` out 1 — load PC from `instr[12:0]`.
- `rd` out 1 — memory read.
- `wr` out 1 — memory write.
- `load_ir` out 1 — instruction register capture enable.
- `datactl_ena` out 1 — drive the accumulator onto the data bus.
- `halt` out 1 — core halted.
- `phase` out 3 — current phase, S0..S7, for debug and verification.

## Operation
- Opcodes:
  - 000 HLT
  - 001 SKZ
  - 010 ADD
  - 011 ANDD
  - 100 XORR
  - 101 LDA
  - 110 STO
  - 111 JMP
- ALU ops are ADD, ANDD, XORR and LDA.
- `phase` is a 3-bit counter. It advances S0→S7→S0 once per clock while `ena`=1 and not halted, and wraps from S7 to S0 with no idle cycle.
- All strobes are registered. On each edge where `ena`=1, the strobes are loaded with the step value for the current `phase` and `phase` increments.
- Any strobe not named for a step is 0. Step values:
  - **S0:** `rd`, `load_ir`, `inc_pc` (fetch high byte).
  - **S1:** `rd`, `load_ir`, `inc_pc` (fetch low byte).
  - **S2:** all 0. The instruction register settles, and the drop of `load_ir` re-arms its byte toggle.
  - **S3:**
    - HLT: `halt`=1 and the sequencer enters the halted condition.
    - Otherwise: all 0.
  - **S4:**
    - ALU op: `rd`.
    - STO: `datactl_ena`.
    - JMP: `load_pc`.
    - Otherwise: 0.
  - **S5:**
    - ALU op: `rd`, `load_acc`.
    - STO: `wr`, `datactl_ena`.
    - JMP: `load_pc`, `inc_pc`.
    - SKZ with `zero`=1: `inc_pc`.
  - **S6:**
    - ALU op: `rd`.
    - STO: `datactl_ena`.
    - JMP: `load_pc`.
    - SKZ with `zero`=1: `inc_pc`.
  - **S7:** all 0.
- SKZ with `zero`=0 produces no strobes in S4–S7.
- Halted condition (sticky):
  - `halt`=1, all other strobes 0, `phase` frozen at S4.
  - Cleared only by `rst`, or by `ena`=0. On `ena`=0, the next edge gives `halt`=0 and `phase`=S0.
- `ena`=0 while not halted: on the next edge all strobes go to 0 and `phase` goes to S0. The interrupted instruction is abandoned. When `ena` returns to 1, execution restarts at S0.
- `rst`=1 has highest priority over `ena` and the halted condition.
- Reset values: all strobes 0, `halt`=0, `phase`=S0.

## Timing
- Step k strobes become visible in the cycle after the edge that samples `phase`=Sk. Equivalently, they coincide with `phase`=Sk+1.
- Latency from reset release with `ena`=1 to the first `rd`/`load_ir` is 1 clock.
- A full instruction takes 8 clocks, for every opcode including SKZ and JMP.
- `opcode` and `zero` are sampled only at the S3–S6 edges. They must be stable from the S3 edge through the S6 edge; changes at other times are ignored.
- `load_ir` is high for exactly 2 consecutive cycles per instruction and low for at least 6 cycles between fetches.
- `wr` is never asserted without `datactl_ena` in the same cycle. `datactl_ena` brackets `wr` by one cycle on each side.
- At most one of `rd` and `wr` is asserted in any cycle.

## Test plan
- **Reset:** hold `rst` 3 cycles with `ena`=1 → all strobes 0 and `phase`=0 throughout. On the first edge after release, `rd`=`load_ir`=`inc_pc`=1, then again the next cycle, then all 0.
- **LDA:** LDA (101) with `ena`=1 → `rd` in steps S4–S6, `load_acc` only in step S5, no `wr`. `phase` returns to 0 after 8 cycles.
- **STO:** STO (110) → `datactl_ena`=1 for steps S4–S6 and `wr`=1 only in step S5. No `rd` outside S0/S1.
- **SKZ and JMP:** SKZ with `zero`=1 → `inc_pc` in steps S5 and S6. SKZ with `zero`=0 → no strobes S4–S7. JMP → `load_pc` in S4–S6 and `inc_pc` only in S5.
- **HLT:** HLT (000) → `halt`=1 from step S3 and `phase` stuck at 4 for 20 cycles with no other strobes. Dropping `ena` for 1 cycle → `halt`=0 and `phase`=0. Raising `ena` again restarts the fetch.
- **Mid-instruction interrupt:** assert `rst` at `phase`=5 during STO → `wr`/`datactl_ena` low at the next edge and `phase`=0. Repeat with `ena`=0 instead of `rst` → same result.
